// File: rtl/sra_multicycle_if.sv
// sra_multicycle_if: start/data_ready handshake bundle for the multi-cycle right shifter.
// master drives start/A/shift/arith; slave returns out/busy/data_ready.
interface sra_multicycle_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);
  logic                   start;
  logic [DATA_WIDTH-1:0]  A;
  logic [SHAMT_WIDTH-1:0] shift;
  logic                   arith;
  logic [DATA_WIDTH-1:0]  out;
  logic                   busy;
  logic                   data_ready;

  modport master (
    output start, A, shift, arith,
    input  out, busy, data_ready
  );

  modport slave (
    input  start, A, shift, arith,
    output out, busy, data_ready
  );
endinterface

// File: rtl/sra_multicycle.sv
// sra_multicycle: logical/arithmetic right shift, one barrel stage per clock.
// Ports: clock, reset (async, active-high), bus (slave: start/A/shift/arith in; out/busy/data_ready out).
module sra_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic            clock,
  input  logic            reset,
  sra_multicycle_if.slave bus
);

  localparam int CW = $clog2(SHAMT_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [SHAMT_WIDTH-1:0] shamt_q, shamt_d;
  logic                   fill_q, fill_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d;

  // Fixed-distance candidate for each stage; the counter picks one per cycle.
  logic [DATA_WIDTH-1:0]  stage_res [SHAMT_WIDTH];

  for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
    assign stage_res[k] = {
      {(1 << k){fill_q}},
      work_q[DATA_WIDTH-1:(1 << k)]
    };
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          work_d  = bus.A;
          shamt_d = bus.shift;
          fill_d  = bus.arith & bus.A[DATA_WIDTH-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shamt_q[cnt_q]) begin
          work_d = stage_res[cnt_q];
        end
        cnt_d = cnt_q + CW'(1);
        // Last stage: publish the finished value in the same edge.
        if (cnt_q == CW'(SHAMT_WIDTH - 1)) begin
          out_d   = work_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      shamt_q <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.data_ready = (state_q == DONE);

endmodule

// File: tb/tb_sra_multicycle.sv
// tb_sra_multicycle: directed and random checks of sra_multicycle
// against a plain-arithmetic shift model.
module tb_sra_multicycle;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [31:0] model_out;

  sra_multicycle_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

  sra_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_sra(input logic [31:0] a,
                                          input int sh, input bit ar);
    logic signed [31:0] s;
    s = a;
    if (ar) return s >>> sh;
    return a >> sh;
  endfunction

  // Call #1 after a rising edge. Returns #1 after the completing edge
  // (the DONE cycle). poke in 0..4 pulses a stray start mid-operation.
  task automatic do_op(input logic [31:0] a, input int sh,
                       input bit ar, input int poke);
    logic [31:0] exp;
    exp = ref_sra(a, sh, ar);
    bus.start = 1'b1;
    bus.A     = a;
    bus.shift = 5'(sh);
    bus.arith = ar;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("busy", {31'b0, bus.busy}, 32'd1);
      chk("dr_low", {31'b0, bus.data_ready}, 32'd0);
      chk("out_hold", bus.out, model_out);
      bus.start = (i == poke);
      bus.A     = (i == poke) ? 32'hFFFF_FFFF : $urandom;
      bus.shift = (i == poke) ? 5'd1 : 5'($urandom);
      bus.arith = 1'($urandom);
      @(posedge clock); #1;
    end
    bus.start = 1'b0;
    chk("dr_high", {31'b0, bus.data_ready}, 32'd1);
    chk("busy_done", {31'b0, bus.busy}, 32'd0);
    chk("result", bus.out, exp);
    model_out = exp;
  endtask

  task automatic idle_chk();
    @(posedge clock); #1;
    chk("idle_dr", {31'b0, bus.data_ready}, 32'd0);
    chk("idle_busy", {31'b0, bus.busy}, 32'd0);
    chk("idle_out", bus.out, model_out);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    model_out = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.shift = '0;
    bus.arith = 1'b0;
    #23;
    chk("rst_out", bus.out, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_dr", {31'b0, bus.data_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    do_op(32'h8000_0000, 4, 1'b0, -1);
    chk("logic4", bus.out, 32'h0800_0000);
    idle_chk();
    do_op(32'h8000_0000, 4, 1'b1, -1);
    chk("arith4", bus.out, 32'hF800_0000);
    idle_chk();
    do_op(32'h8000_0000, 31, 1'b1, -1);
    chk("arith31", bus.out, 32'hFFFF_FFFF);
    idle_chk();
    do_op(32'h8000_0000, 31, 1'b0, -1);
    chk("logic31", bus.out, 32'h0000_0001);
    idle_chk();
    do_op(32'h7FFF_FFFF, 31, 1'b1, -1);
    chk("pos31", bus.out, 32'h0000_0000);
    idle_chk();
    do_op(32'hDEAD_BEEF, 0, 1'b1, -1);
    chk("zero", bus.out, 32'hDEAD_BEEF);
    idle_chk();
    do_op(32'h0000_FF00, 8, 1'b0, 2);
    chk("ignore", bus.out, 32'h0000_00FF);
    idle_chk();
    idle_chk();

    do_op(32'h0F0F_0000, 4, 1'b0, -1);
    do_op(32'hF000_0000, 16, 1'b1, -1);
    chk("b2b", bus.out, 32'hFFFF_F000);
    idle_chk();

    // Asynchronous reset between edges, two edges into an operation.
    bus.start = 1'b1;
    bus.A     = 32'h1234_5678;
    bus.shift = 5'd3;
    bus.arith = 1'b0;
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    model_out = '0;
    chk("mid_rst_out", bus.out, 32'd0);
    chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("mid_rst_dr", {31'b0, bus.data_ready}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      chk("post_rst_dr", {31'b0, bus.data_ready}, 32'd0);
    end
    do_op(32'h1234_5678, 3, 1'b0, -1);
    chk("after_rst", bus.out, 32'h0246_8ACF);
    idle_chk();

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int sh;
      int sel;
      int p;
      a   = $urandom;
      sel = $urandom_range(0, 7);
      sh  = (sel == 0) ? 0 : (sel == 1) ? 31 : $urandom_range(0, 31);
      p   = $urandom_range(0, 9);
      do_op(a, sh, 1'($urandom), (p < 5) ? p : -1);
      if ($urandom_range(0, 1) == 0) idle_chk();
    end
    idle_chk();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
